// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the shift
// sequence controller and its bit-period divider.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV_W = 8;

  function automatic int bit_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_div_tick.sv
// Loadable down-counter; tick marks the last
// clock of a bit period.
module shift_div_tick
  import shift_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame controller: parallel word out MSB-first on
// sout, sin captured into rx_data over the same bits.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [DIV_W-1:0] div,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int BW = bit_cnt_w(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] ld_val;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             accept;
  logic             step;
  logic             in_shift;

  assign in_shift = (state == SHIFT);
  assign accept   = (state == IDLE) & tx_valid;
  assign step     = in_shift & tick;
  assign ld_val   = accept ? div : div_lat;
  assign rx_next  = {rx_shift[WIDTH-2:0], sin};

  assign tx_ready = (state == IDLE);
  assign busy     = in_shift;
  assign sout     = in_shift & tx_shift[WIDTH-1];
  assign rx_valid = (state == DONE);

  shift_div_tick #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .load    (accept | step),
    .load_val(ld_val),
    .en      (in_shift),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      div_lat  <= '0;
      bit_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            div_lat  <= div;
            bit_cnt  <= BW'(WIDTH - 1);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            rx_shift <= rx_next;
            if (bit_cnt == '0) begin
              // publish together with the DONE-cycle pulse
              rx_data <= rx_next;
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl
// (WIDTH=4, DIV_W=8).
module tb_shift_seq_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] div;
  logic       sin_w;
  logic       sin_v;
  logic       loop;
  logic       sout;
  logic       busy;
  logic [3:0] rx_data;
  logic       rx_valid;

  int n_cmp;
  int n_err;

  assign sin_w = loop ? sout : sin_v;

  shift_seq_ctrl #(
    .WIDTH(4),
    .DIV_W(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .div     (div),
    .sin     (sin_w),
    .sout    (sout),
    .busy    (busy),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake one word; returns at mid-cycle 1 of the frame.
  task automatic start(input logic [3:0] d, input logic [7:0] dv);
    @(negedge clk);
    tx_data  = d;
    div      = dv;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    n_cmp++;
    if ({tx_ready, sout, busy, rx_valid, rx_data} !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL reset_vals: got %b want 10000000",
               {tx_ready, sout, busy, rx_valid, rx_data});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b busy=%b want 1/0",
               tx_ready, busy);
    end
  endtask

  task automatic test_loopback;
    logic [3:0] d;
    d    = 4'b1010;
    loop = 1'b1;
    start(d, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (sout !== d[4-c] || busy !== 1'b1 || tx_ready !== 1'b0) begin
        n_err++;
        $display("FAIL lb_bit c=%0d: sout=%b busy=%b rdy=%b want %b/1/0",
                 c, sout, busy, tx_ready, d[4-c]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== d || busy !== 1'b0 ||
        tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL lb_done: v=%b data=%b busy=%b rdy=%b want 1/%b/0/0",
               rx_valid, rx_data, busy, tx_ready, d);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lb_idle: rdy=%b v=%b want 1/0", tx_ready, rx_valid);
    end
  endtask

  task automatic test_div2;
    logic [3:0] d;
    int         pulses;
    d      = 4'b0011;
    loop   = 1'b0;
    sin_v  = 1'b1;
    pulses = 0;
    start(d, 8'd2);
    for (int c = 1; c <= 12; c++) begin
      if (rx_valid) pulses++;
      n_cmp++;
      if (sout !== d[3-(c-1)/3] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL div2_bit c=%0d: sout=%b busy=%b want %b/1",
                 c, sout, busy, d[3-(c-1)/3]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 4'b1111) begin
      n_err++;
      $display("FAIL div2_done: v=%b data=%b want 1/1111",
               rx_valid, rx_data);
    end
    @(negedge clk);
    if (rx_valid) pulses++;
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL div2_pulse: extra=%0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a;
    logic [3:0] b;
    logic       exp_rdy;
    logic       exp_out;
    int         acc;
    a    = 4'b1100;
    b    = 4'b0110;
    acc  = 0;
    loop = 1'b1;
    @(negedge clk);
    tx_data  = a;
    div      = 8'd0;
    tx_valid = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) tx_data = b;
      if (c == 7) tx_valid = 1'b0;
      if (tx_valid && tx_ready) acc++;
      exp_rdy = (c == 0 || c == 6 || c == 12);
      n_cmp++;
      if (tx_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_rdy c=%0d: rdy=%b want %b",
                 c, tx_ready, exp_rdy);
      end
      exp_out = 1'b0;
      if (c >= 1 && c <= 4) exp_out = a[4-c];
      if (c >= 7 && c <= 10) exp_out = b[10-c];
      n_cmp++;
      if (sout !== exp_out) begin
        n_err++;
        $display("FAIL b2b_sout c=%0d: sout=%b want %b",
                 c, sout, exp_out);
      end
      if (c == 5 || c == 11) begin
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== ((c == 5) ? a : b)) begin
          n_err++;
          $display("FAIL b2b_rx c=%0d: v=%b data=%b want 1/%b",
                   c, rx_valid, rx_data, (c == 5) ? a : b);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (acc != 2) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d want 2", acc);
    end
  endtask

  task automatic test_div_change;
    logic [3:0] d;
    d    = 4'b1001;
    loop = 1'b1;
    start(d, 8'd1);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) div = 8'd5;
      n_cmp++;
      if (sout !== d[3-(c-1)/2] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL dchg_bit c=%0d: sout=%b busy=%b want %b/1",
                 c, sout, busy, d[3-(c-1)/2]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== d) begin
      n_err++;
      $display("FAIL dchg_done: v=%b data=%b want 1/%b",
               rx_valid, rx_data, d);
    end
    d = 4'b0101;
    start(d, 8'd5);
    for (int c = 1; c <= 24; c++) begin
      n_cmp++;
      if (sout !== d[3-(c-1)/6] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL dchg2_bit c=%0d: sout=%b busy=%b want %b/1",
                 c, sout, busy, d[3-(c-1)/6]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== d) begin
      n_err++;
      $display("FAIL dchg2_done: v=%b data=%b want 1/%b",
               rx_valid, rx_data, d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    loop   = 1'b1;
    start(4'b1111, 8'd1);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sout !== 1'b1 || busy !== 1'b1 || rx_data !== 4'b0101) begin
      n_err++;
      $display("FAIL rmid_pre: sout=%b busy=%b data=%b want 1/1/0101",
               sout, busy, rx_data);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({sout, busy, rx_valid, rx_data} !== 7'b0) begin
      n_err++;
      $display("FAIL rmid_async: got %b want 0000000",
               {sout, busy, rx_valid, rx_data});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_rdy: rdy=%b want 1", tx_ready);
    end
    for (int c = 0; c < 12; c++) begin
      if (rx_valid) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses != 0 || rx_data !== 4'b0000) begin
      n_err++;
      $display("FAIL rmid_nopulse: pulses=%0d data=%b want 0/0000",
               pulses, rx_data);
    end
  endtask

  task automatic test_div_max;
    logic [3:0] d;
    int         early;
    d     = 4'b0110;
    loop  = 1'b1;
    early = 0;
    start(d, 8'hFF);
    for (int c = 1; c <= 1024; c++) begin
      if (rx_valid || !busy) early++;
      if ((c % 256) == 1 || (c % 256) == 0) begin
        n_cmp++;
        if (sout !== d[3-(c-1)/256]) begin
          n_err++;
          $display("FAIL dmax_bit c=%0d: sout=%b want %b",
                   c, sout, d[3-(c-1)/256]);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL dmax_early: cycles=%0d want 0", early);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== d || busy !== 1'b0) begin
      n_err++;
      $display("FAIL dmax_done: v=%b data=%b busy=%b want 1/%b/0",
               rx_valid, rx_data, busy, d);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dmax_idle: rdy=%b v=%b want 1/0", tx_ready, rx_valid);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    div      = '0;
    sin_v    = 1'b0;
    loop     = 1'b0;
    test_reset();
    test_loopback();
    test_div2();
    test_back_to_back();
    test_div_change();
    test_reset_mid();
    test_div_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Frame controller for a WIDTH-bit shift register pair: one parallel-in/serial-out path and one serial-in/parallel-out path.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB first at a programmable bit rate.
- Captures the incoming serial line into a parallel word over the same bit periods, then reports it with a one-cycle valid pulse.
- Sits between a parallel producer/consumer and a serial link, or a loopback bench.

Parameters:
WIDTH, 4, frame length in bits (>=2)
DIV_W, 8, width of bit-period divider

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  WIDTH  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  controller can accept a word
div  input  DIV_W  bit period minus one, in clk cycles
sin  input  1  serial receive line
sout  output  1  serial transmit line
busy  output  1  frame in progress
rx_data  output  WIDTH  last received word
rx_valid  output  1  one-cycle pulse, rx_data updated

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - reset is asynchronous and active-low. While reset=0, state=IDLE and every register clears.
  - Reset values: tx_ready=1, sout=0, busy=0, rx_data=0, rx_valid=0.
  - Asserting reset mid-frame aborts the frame. No rx_valid is produced for it, and rx_data returns to 0.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - tx_ready=1, busy=0, sout=0.
  - On the edge where tx_valid=1, latch tx_data into tx_shift, latch div into div_lat, set div_cnt=div, set bit_cnt=WIDTH-1, and go to SHIFT.
- SHIFT:
  - tx_ready=0, busy=1, sout=tx_shift[WIDTH-1].
  - div_cnt decrements each cycle. tick = (div_cnt==0).
  - On tick:
    - tx_shift shifts left, filling with 0.
    - rx_shift shifts left, filling with sin, so sin is sampled in the last cycle of each bit period.
    - div_cnt reloads from div_lat.
    - If bit_cnt==0, go to DONE; otherwise bit_cnt decrements.
- DONE (one cycle):
  - rx_data <= rx_shift, giving a word with the first received bit in the MSB.
  - rx_valid=1 for exactly this cycle.
  - tx_ready=0 and busy=0. Return to IDLE.
- Timing:
  - Frame length is WIDTH*(div+1) cycles in SHIFT, plus one DONE cycle.
  - The next word is accepted no earlier than the cycle after DONE.
- Control-input rules:
  - div changes during a frame have no effect; only the value latched at acceptance is used.
  - div=0 gives one cycle per bit. div=all-ones gives 2^DIV_W cycles per bit with no overflow; div_cnt is DIV_W bits.
  - tx_valid while tx_ready=0 is ignored. The producer must hold tx_valid and tx_data until the handshake occurs.
- rx_data holds its value between frames and is never X after reset.
- Bit counter width is clog2(WIDTH). With WIDTH a power of two, bit_cnt wraps nowhere because termination is at 0.

Decomposition:
- Shared package shift_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - default WIDTH and DIV_W localparams
  - bit-counter width function
- One natural sub-module, shift_div_tick: a loadable down-counter producing tick, with inputs load, load_val and en.
- Shift registers stay inline in the controller.

Test Plan:
- WIDTH=4, div=0, loopback sin=sout, tx_data=4'b1010 accepted at cycle 0:
  - sout=1,0,1,0 on cycles 1-4
  - rx_valid pulses on cycle 5 with rx_data=4'b1010
  - tx_ready returns to 1 on cycle 6
- div=2, tx_data=4'b0011, sin held at 1:
  - each sout bit lasts 3 cycles, 12 cycles total
  - rx_data=4'b1111, rx_valid high exactly one cycle
- tx_valid held continuously with new data every acceptance:
  - exactly one acceptance per frame
  - tx_ready low for the entire frame plus DONE
  - a second word is not lost and is sent next
- div changed from 1 to 5 mid-frame:
  - bit period stays 2 cycles until the frame ends
  - the next frame uses 6 cycles per bit
- reset driven low during bit 2 of a frame:
  - sout, busy, rx_valid and rx_data go 0 immediately (asynchronously)
  - tx_ready=1 after release
  - no rx_valid pulse for the aborted frame
- div=8'hFF, WIDTH=4:
  - frame lasts 1024 SHIFT cycles, then DONE
  - sampled word is correct and no early tick occurs
